// File: rtl/sfp2fix_block_if.sv
// Purpose: handshake and data bundle between an SFP word source, the
//   sfp2fix_block aligner and the fixed-point consumer.
// Ports (signals):
//   in_valid/in_ready/sfp_in            SFP input channel
//   out_valid/out_ready/fix_out         aligned fixed-point output channel
//   out_last                            marks the final word of a frame
//   max_exp                             shared frame exponent
// Modports: master = source/sink side (testbench), slave = the aligner.
interface sfp2fix_block_if #(
  parameter int expWidth   = 4,
  parameter int sigWidth   = 4,
  parameter int low_expand = 2
);
  localparam int FMT_W = 1 + expWidth + sigWidth;
  localparam int FIX_W = sigWidth + 4 + low_expand;

  logic              in_valid;
  logic              in_ready;
  logic [FMT_W-1:0]  sfp_in;
  logic              out_valid;
  logic              out_ready;
  logic [FIX_W-1:0]  fix_out;
  logic              out_last;
  logic [expWidth-1:0] max_exp;

  modport master (
    output in_valid, sfp_in, out_ready,
    input  in_ready, out_valid, fix_out, out_last, max_exp
  );

  modport slave (
    input  in_valid, sfp_in, out_ready,
    output in_ready, out_valid, fix_out, out_last, max_exp
  );
endinterface

// File: rtl/sfp2fix_block.sv
// Purpose: block-floating-point aligner. Buffers a frame of BLOCK_LEN SFP
//   words, tracks the frame's maximum exponent, then emits each word as a
//   two's-complement fixed-point value aligned to that shared exponent.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   sfp2fix_block_if.slave: SFP input channel, fixed-point output
//         channel with out_last, and the frame's max_exp
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_COLLECT | accepting SFP words into the buffer, tracking running max exp
// S_EMIT    | presenting aligned words one per output handshake
module sfp2fix_block #(
  parameter int expWidth    = 4,
  parameter int sigWidth    = 4,
  parameter int formatWidth = 9,
  parameter int low_expand  = 2,
  parameter int BLOCK_LEN   = 4
) (
  input  logic clk,
  input  logic rst,
  sfp2fix_block_if.slave bus
);

  localparam int FIX_W = sigWidth + 4 + low_expand;
  localparam int MAG_W = sigWidth + 1 + low_expand;
  localparam int CNT_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_LEN - 1);

  typedef enum logic {S_COLLECT, S_EMIT} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [expWidth-1:0]    run_max_q, run_max_d;
  logic [expWidth-1:0]    max_exp_q, max_exp_d;
  logic [formatWidth-1:0] buf_mem_q [BLOCK_LEN];
  logic [formatWidth-1:0] buf_mem_d [BLOCK_LEN];

  // Incoming word fields
  logic [expWidth-1:0]    in_exp;
  logic [expWidth-1:0]    new_max;

  // Alignment of the buffered word selected by count
  logic [formatWidth-1:0] cur_w;
  logic                   cur_sign;
  logic [expWidth-1:0]    cur_exp;
  logic [sigWidth-1:0]    cur_man;
  logic [MAG_W-1:0]       mag;
  logic [MAG_W-1:0]       mag_s;
  logic [expWidth-1:0]    shift;
  logic [FIX_W-1:0]       mag_ext;
  logic [FIX_W-1:0]       fix_aligned;

  always_comb begin
    cur_w    = buf_mem_q[count_q];
    cur_sign = cur_w[formatWidth-1];
    cur_exp  = cur_w[sigWidth +: expWidth];
    cur_man  = cur_w[sigWidth-1:0];
    mag      = MAG_W'({1'b1, cur_man}) << low_expand;
    // max_exp is the frame maximum, so this never wraps
    shift    = max_exp_q - cur_exp;
    // Shifts wider than the magnitude naturally yield 0
    mag_s    = mag >> shift;
    mag_ext  = FIX_W'(mag_s);
    if (cur_exp == '0) begin
      fix_aligned = '0;
    end else if (cur_sign) begin
      // Negating 0 gives 0, so an underflowed negative word cannot become -0
      fix_aligned = -mag_ext;
    end else begin
      fix_aligned = mag_ext;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    run_max_d = run_max_q;
    max_exp_d = max_exp_q;
    buf_mem_d = buf_mem_q;

    in_exp  = bus.sfp_in[sigWidth +: expWidth];
    // Zero words have exp 0, which can never raise the running max
    new_max = (in_exp > run_max_q) ? in_exp : run_max_q;

    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.fix_out   = '0;

    case (state_q)
      S_COLLECT: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          buf_mem_d[count_q] = bus.sfp_in;
          run_max_d          = new_max;
          if (count_q == LAST_IDX) begin
            max_exp_d = new_max;
            count_d   = '0;
            state_d   = S_EMIT;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      S_EMIT: begin
        bus.out_valid = 1'b1;
        bus.out_last  = (count_q == LAST_IDX);
        bus.fix_out   = fix_aligned;
        if (bus.out_ready) begin
          if (count_q == LAST_IDX) begin
            count_d   = '0;
            run_max_d = '0;
            state_d   = S_COLLECT;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_COLLECT;
      end
    endcase
  end

  assign bus.max_exp = max_exp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_COLLECT;
      count_q   <= '0;
      run_max_q <= '0;
      max_exp_q <= '0;
      for (int i = 0; i < BLOCK_LEN; i++) begin
        buf_mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      run_max_q <= run_max_d;
      max_exp_q <= max_exp_d;
      buf_mem_q <= buf_mem_d;
    end
  end

endmodule
